injector_run_controller: RTL and testbench

Sequences one measurement run of the massive traffic injector: warm-up hold, packet-budgeted run, a paced stop-command sweep across a queue index range, then drain. It drives the injector's enable and stop_queue_idx/stop_cmd_valid inputs and watches its packet output handshake and scheduler_active status. It also reports run statistics and a completion pulse to the host/CSR layer.

---
 rtl/injector_run_controller.sv | 200 ++++++++++++++++++++
 tb/tb_injector_run_controller.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/injector_run_controller.sv
// Run sequencer for the traffic injector: warm-up, packet-budgeted run, paced stop sweep, drain.
// Reports packet/cycle statistics and a one-cycle completion pulse.
module injector_run_controller #(
    parameter int unsigned QUEUE_INDEX_WIDTH = 16,
    parameter int unsigned TIMER_WIDTH       = 32,
    parameter int unsigned GAP_WIDTH         = 16,
    parameter int unsigned DRAIN_QUIET       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_start,
    input  logic                         cfg_abort,
    input  logic [TIMER_WIDTH-1:0]       cfg_warmup_cycles,
    input  logic [63:0]                  cfg_run_pkts,
    input  logic [QUEUE_INDEX_WIDTH-1:0] cfg_stop_first,
    input  logic [QUEUE_INDEX_WIDTH-1:0] cfg_stop_last,
    input  logic [GAP_WIDTH-1:0]         cfg_stop_gap,
    input  logic                         mon_tvalid,
    input  logic                         mon_tready,
    input  logic                         mon_tlast,
    input  logic                         sched_active,
    output logic                         injector_enable,
    output logic [QUEUE_INDEX_WIDTH-1:0] stop_queue_idx,
    output logic                         stop_cmd_valid,
    output logic                         busy,
    output logic                         done,
    output logic [2:0]                   state_o,
    output logic [63:0]                  pkt_count,
    output logic [TIMER_WIDTH-1:0]       run_cycles
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWarmup = 3'd1;
    localparam logic [2:0] StRun    = 3'd2;
    localparam logic [2:0] StSweep  = 3'd3;
    localparam logic [2:0] StDrain  = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    localparam int unsigned QuietWidth = $clog2(DRAIN_QUIET + 1);
    localparam logic [QuietWidth-1:0] QuietLast = QuietWidth'(DRAIN_QUIET - 1);

    logic [2:0]                   state_q, state_d;
    logic [TIMER_WIDTH-1:0]       warm_q, warm_d;
    logic [63:0]                  run_pkts_q;
    logic [QUEUE_INDEX_WIDTH-1:0] first_q, last_q;
    logic [GAP_WIDTH-1:0]         gap_q;
    logic [GAP_WIDTH-1:0]         gap_cnt_q, gap_cnt_d;
    logic [QUEUE_INDEX_WIDTH-1:0] remain_q, remain_d;
    logic [QUEUE_INDEX_WIDTH-1:0] idx_q, idx_d;
    logic                         valid_q, valid_d;
    logic [QuietWidth-1:0]        quiet_q, quiet_d;
    logic                         in_pkt_q;
    logic [63:0]                  pkt_count_q;
    logic [TIMER_WIDTH-1:0]       run_cycles_q;
    logic                         enable_q, busy_q, done_q;

    logic start_acc, pkt_fire, pkt_end, quiet, step;

    assign start_acc = (state_q == StIdle) & cfg_start;
    assign pkt_fire  = mon_tvalid & mon_tready;
    assign pkt_end   = pkt_fire & mon_tlast;
    assign quiet     = ~sched_active & ~in_pkt_q;

    always_comb begin
        state_d   = state_q;
        warm_d    = warm_q;
        gap_cnt_d = gap_cnt_q;
        remain_d  = remain_q;
        idx_d     = idx_q;
        valid_d   = 1'b0;
        quiet_d   = quiet_q;
        step      = 1'b0;
        case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    state_d = StWarmup;
                    warm_d  = (cfg_warmup_cycles == '0) ? TIMER_WIDTH'(1) : cfg_warmup_cycles;
                end
            end
            StWarmup: begin
                if (cfg_abort) begin
                    state_d = StDrain;
                    quiet_d = '0;
                end else if (warm_q <= TIMER_WIDTH'(1)) begin
                    state_d = StRun;
                end else begin
                    warm_d = warm_q - TIMER_WIDTH'(1);
                end
            end
            StRun: begin
                if (cfg_abort) begin
                    state_d = StDrain;
                    quiet_d = '0;
                end else if (pkt_count_q >= run_pkts_q) begin
                    // First stop pulse coincides with the first SWEEP cycle
                    state_d  = StSweep;
                    valid_d  = 1'b1;
                    idx_d    = first_q;
                    remain_d = last_q - first_q;
                end
            end
            StSweep: begin
                if (cfg_abort) begin
                    state_d = StDrain;
                    quiet_d = '0;
                end else if (valid_q) begin
                    if (remain_q == '0) begin
                        state_d = StDrain;
                        quiet_d = '0;
                    end else if (gap_q == '0) begin
                        step = 1'b1;
                    end else begin
                        gap_cnt_d = gap_q;
                    end
                end else if (gap_cnt_q <= GAP_WIDTH'(1)) begin
                    step = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end
            StDrain: begin
                if (!quiet) begin
                    quiet_d = '0;
                end else if (quiet_q == QuietLast) begin
                    state_d = StDone;
                end else begin
                    quiet_d = quiet_q + QuietWidth'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (step) begin
            valid_d  = 1'b1;
            idx_d    = idx_q + QUEUE_INDEX_WIDTH'(1);
            remain_d = remain_q - QUEUE_INDEX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            warm_q       <= '0;
            run_pkts_q   <= '0;
            first_q      <= '0;
            last_q       <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            remain_q     <= '0;
            idx_q        <= '0;
            valid_q      <= 1'b0;
            quiet_q      <= '0;
            in_pkt_q     <= 1'b0;
            pkt_count_q  <= '0;
            run_cycles_q <= '0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            warm_q    <= warm_d;
            gap_cnt_q <= gap_cnt_d;
            remain_q  <= remain_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            quiet_q   <= quiet_d;
            enable_q  <= (state_d == StRun) || (state_d == StSweep);
            busy_q    <= state_d != StIdle;
            done_q    <= state_d == StDone;
            if (pkt_fire) begin
                in_pkt_q <= ~mon_tlast;
            end
            if (start_acc) begin
                run_pkts_q   <= cfg_run_pkts;
                first_q      <= cfg_stop_first;
                last_q       <= cfg_stop_last;
                gap_q        <= cfg_stop_gap;
                pkt_count_q  <= '0;
                run_cycles_q <= '0;
            end else begin
                if (state_q != StIdle && pkt_end && pkt_count_q != '1) begin
                    pkt_count_q <= pkt_count_q + 64'd1;
                end
                if (enable_q && run_cycles_q != '1) begin
                    run_cycles_q <= run_cycles_q + TIMER_WIDTH'(1);
                end
            end
        end
    end

    assign injector_enable = enable_q;
    assign stop_queue_idx  = idx_q;
    assign stop_cmd_valid  = valid_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign state_o         = state_q;
    assign pkt_count       = pkt_count_q;
    assign run_cycles      = run_cycles_q;

endmodule

// File: tb/tb_injector_run_controller.sv
// Directed bench for injector_run_controller: table of full runs plus drain-hold,
// abort and mid-run reset sequences.
module tb_injector_run_controller;

    localparam int QW = 16;
    localparam int TW = 32;
    localparam int GW = 16;
    localparam int DQ = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_abort = 1'b0;
    logic [TW-1:0] cfg_warmup_cycles = '0;
    logic [63:0]   cfg_run_pkts = '0;
    logic [QW-1:0] cfg_stop_first = '0;
    logic [QW-1:0] cfg_stop_last = '0;
    logic [GW-1:0] cfg_stop_gap = '0;
    logic          mon_tvalid = 1'b0;
    logic          mon_tready = 1'b0;
    logic          mon_tlast = 1'b0;
    logic          sched_active = 1'b0;
    logic          injector_enable;
    logic [QW-1:0] stop_queue_idx;
    logic          stop_cmd_valid;
    logic          busy;
    logic          done;
    logic [2:0]    state_o;
    logic [63:0]   pkt_count;
    logic [TW-1:0] run_cycles;

    injector_run_controller #(
        .QUEUE_INDEX_WIDTH(QW),
        .TIMER_WIDTH      (TW),
        .GAP_WIDTH        (GW),
        .DRAIN_QUIET      (DQ)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_start        (cfg_start),
        .cfg_abort        (cfg_abort),
        .cfg_warmup_cycles(cfg_warmup_cycles),
        .cfg_run_pkts     (cfg_run_pkts),
        .cfg_stop_first   (cfg_stop_first),
        .cfg_stop_last    (cfg_stop_last),
        .cfg_stop_gap     (cfg_stop_gap),
        .mon_tvalid       (mon_tvalid),
        .mon_tready       (mon_tready),
        .mon_tlast        (mon_tlast),
        .sched_active     (sched_active),
        .injector_enable  (injector_enable),
        .stop_queue_idx   (stop_queue_idx),
        .stop_cmd_valid   (stop_cmd_valid),
        .busy             (busy),
        .done             (done),
        .state_o          (state_o),
        .pkt_count        (pkt_count),
        .run_cycles       (run_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] warmup;
        logic [63:0] run_pkts;
        logic [15:0] first;
        logic [15:0] last;
        logic [15:0] gap;
        int          en_at;      // negedge index (after start) where enable first seen
        int          run_len;
        int          npulse;
        logic [15:0] idx_first;
        logic [15:0] idx_last;
        int          spacing;
        int          sweep_len;
        int          en_cycles;
    } vec_t;

    vec_t vecs[5];

    task automatic set_cfg(input logic [31:0] w, input logic [63:0] p, input logic [15:0] f,
                           input logic [15:0] l, input logic [15:0] g);
        cfg_warmup_cycles = w;
        cfg_run_pkts      = p;
        cfg_stop_first    = f;
        cfg_stop_last     = l;
        cfg_stop_gap      = g;
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int          en_at, run_len, sweep_len, drain_len, en_cycles, npulse;
        int          first_t, last_t, bad_space, bad_seq, bad_en;
        logic [15:0] first_idx, prev_idx;
        logic [63:0] exp_pkts;
        bit          done_seen;
        en_at = -1; run_len = 0; sweep_len = 0; drain_len = 0; en_cycles = 0; npulse = 0;
        first_t = 0; last_t = 0; bad_space = 0; bad_seq = 0; bad_en = 0;
        first_idx = '0; prev_idx = '0; exp_pkts = '0; done_seen = 1'b0;
        @(negedge clk);
        set_cfg(v.warmup, v.run_pkts, v.first, v.last, v.gap);
        cfg_start  = 1'b1;
        mon_tvalid = 1'b0;
        mon_tready = 1'b1;
        mon_tlast  = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check($sformatf("v%0d_pkt_cleared", vi), pkt_count, 64'd0);
                check($sformatf("v%0d_cyc_cleared", vi), 64'(run_cycles), 64'd0);
                check($sformatf("v%0d_warmup_state", vi), 64'(state_o), 64'd1);
                // Config changes after the accepted start must be ignored
                set_cfg(32'd77, 64'd999, ~v.first, v.first, 16'd9);
            end
            cfg_start = (n == 3);
            if (injector_enable) begin
                en_cycles++;
                if (en_at < 0) en_at = n;
            end
            if (state_o == 3'd2) run_len++;
            if (state_o == 3'd3) sweep_len++;
            if (state_o == 3'd4) drain_len++;
            if (stop_cmd_valid) begin
                npulse++;
                if (npulse == 1) begin
                    first_idx = stop_queue_idx;
                    first_t   = n;
                end else begin
                    if (n - last_t != v.spacing) bad_space++;
                    if (stop_queue_idx != 16'(prev_idx + 16'd1)) bad_seq++;
                end
                if (!injector_enable) bad_en++;
                last_t   = n;
                prev_idx = stop_queue_idx;
            end
            if (done) begin
                done_seen = 1'b1;
                check($sformatf("v%0d_pkt_count", vi), pkt_count, exp_pkts);
                check($sformatf("v%0d_run_cycles", vi), 64'(run_cycles), 64'(v.en_cycles));
            end
            mon_tvalid = injector_enable;
            if (injector_enable) exp_pkts++;
            if (done_seen) break;
        end
        cfg_start  = 1'b0;
        mon_tvalid = 1'b0;
        check($sformatf("v%0d_done_reached", vi), 64'(done_seen), 64'd1);
        check($sformatf("v%0d_en_at", vi), 64'(en_at), 64'(v.en_at));
        check($sformatf("v%0d_run_len", vi), 64'(run_len), 64'(v.run_len));
        check($sformatf("v%0d_sweep_len", vi), 64'(sweep_len), 64'(v.sweep_len));
        check($sformatf("v%0d_drain_len", vi), 64'(drain_len), 64'(DQ));
        check($sformatf("v%0d_en_cycles", vi), 64'(en_cycles), 64'(v.en_cycles));
        check($sformatf("v%0d_npulse", vi), 64'(npulse), 64'(v.npulse));
        check($sformatf("v%0d_first_idx", vi), 64'(first_idx), 64'(v.idx_first));
        check($sformatf("v%0d_last_idx", vi), 64'(prev_idx), 64'(v.idx_last));
        check($sformatf("v%0d_first_pulse_t", vi), 64'(first_t), 64'(v.en_at + v.run_len));
        check($sformatf("v%0d_spacing_errs", vi), 64'(bad_space), 64'd0);
        check($sformatf("v%0d_seq_errs", vi), 64'(bad_seq), 64'd0);
        check($sformatf("v%0d_pulse_no_en", vi), 64'(bad_en), 64'd0);
        @(negedge clk);
        check($sformatf("v%0d_done_width", vi), 64'(done), 64'd0);
        check($sformatf("v%0d_busy_after", vi), 64'(busy), 64'd0);
        check($sformatf("v%0d_idle_after", vi), 64'(state_o), 64'd0);
    endtask

    initial begin
        int          k, npulse, drain_len;
        bit          done_seen, done_early;
        logic [15:0] last_idx;

        //             warm   pkts  first     last      gap  en run N  idxF      idxL      sp swp enc
        vecs[0] = '{32'd10, 64'd5, 16'd7,    16'd7,    16'd0, 11, 6, 1, 16'd7,    16'd7,    1, 1,  7};
        vecs[1] = '{32'd2,  64'd3, 16'd3,    16'd6,    16'd2, 3,  4, 4, 16'd3,    16'd6,    3, 10, 14};
        vecs[2] = '{32'd1,  64'd2, 16'hFFFE, 16'h0001, 16'd0, 2,  3, 4, 16'hFFFE, 16'h0001, 1, 4,  7};
        vecs[3] = '{32'd0,  64'd0, 16'd5,    16'd5,    16'd1, 2,  1, 1, 16'd5,    16'd5,    2, 1,  2};
        vecs[4] = '{32'd3,  64'd1, 16'd10,   16'd12,   16'd1, 4,  2, 3, 16'd10,   16'd12,   2, 5,  7};

        repeat (3) @(negedge clk);
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_enable", 64'(injector_enable), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stop_valid", 64'(stop_cmd_valid), 64'd0);
        check("rst_pkt_count", pkt_count, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Drain held off by an open packet and an active scheduler
        @(negedge clk);
        set_cfg(32'd0, 64'd0, 16'd1, 16'd1, 16'd0);
        cfg_start    = 1'b1;
        mon_tvalid   = 1'b1;
        mon_tready   = 1'b1;
        mon_tlast    = 1'b0;
        sched_active = 1'b1;
        @(negedge clk);
        cfg_start  = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b1;
        done_early = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done) done_early = 1'b1;
        end
        check("hold_no_done", 64'(done_early), 64'd0);
        check("hold_in_drain", 64'(state_o), 64'd4);
        check("hold_pkt_count", pkt_count, 64'd0);
        mon_tready   = 1'b1;
        sched_active = 1'b0;
        k = -1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            mon_tvalid = 1'b0;
            if (done) begin
                k = n;
                break;
            end
        end
        check("hold_release_latency", 64'(k), 64'(DQ + 1));
        check("hold_pkt_after", pkt_count, 64'd1);
        check("hold_run_cycles", 64'(run_cycles), 64'd2);

        // Abort during a 100-queue sweep after 10 pulses; start+abort together in IDLE
        @(negedge clk);
        set_cfg(32'd0, 64'd0, 16'd0, 16'd99, 16'd0);
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        check("start_beats_abort", 64'(state_o), 64'd1);
        npulse = 0; drain_len = 0; done_seen = 1'b0; last_idx = '0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            cfg_abort = 1'b0;
            if (state_o == 3'd4) begin
                drain_len++;
                if (drain_len == 2) cfg_abort = 1'b1;
            end
            if (stop_cmd_valid) begin
                npulse++;
                last_idx = stop_queue_idx;
                if (npulse == 10) begin
                    cfg_abort = 1'b1;
                    @(negedge clk);
                    cfg_abort = 1'b0;
                    check("abort_no_pulse", 64'(stop_cmd_valid), 64'd0);
                    check("abort_enable_low", 64'(injector_enable), 64'd0);
                    check("abort_to_drain", 64'(state_o), 64'd4);
                    drain_len++;
                end
            end
            if (done) begin
                done_seen = 1'b1;
                break;
            end
        end
        cfg_abort = 1'b0;
        check("abort_done", 64'(done_seen), 64'd1);
        check("abort_npulse", 64'(npulse), 64'd10);
        check("abort_last_idx", 64'(last_idx), 64'd9);
        check("abort_drain_len", 64'(drain_len), 64'(DQ));

        // Reset in the middle of RUN
        @(negedge clk);
        set_cfg(32'd0, 64'd1000, 16'd0, 16'd0, 16'd0);
        cfg_start  = 1'b1;
        mon_tready = 1'b1;
        mon_tlast  = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            cfg_start  = 1'b0;
            mon_tvalid = injector_enable;
        end
        check("pre_rst_run", 64'(state_o), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_enable", 64'(injector_enable), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_state", 64'(state_o), 64'd0);
        check("mid_rst_pkt", pkt_count, 64'd0);
        check("mid_rst_cycles", 64'(run_cycles), 64'd0);
        check("mid_rst_stop", 64'(stop_cmd_valid), 64'd0);
        mon_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'(state_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
